tree_vote_sequencer: RTL and testbench

Sequences one shared bank of combinational decision-tree classifiers so they evaluate a single feature vector, one tree at a time, and combines the results by majority vote. The block holds the feature vector and drives the tree select lines. It samples each tree's 1-bit class decision, counts the votes, and returns a voted class through a valid/ready interface. It sits between the feature source and the ensemble output, wrapping the generated tree modules (51-bit feature vector, 1-bit class out).

---
 rtl/tree_vote_sequencer.sv | 175 +++++++++++++++++
 tb/tb_tree_vote_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tree_vote_sequencer.sv
// tree_vote_sequencer
// Time-multiplexes one shared bank of combinational decision trees over a
// single latched feature vector. It evaluates the enabled trees one at a time
// and majority-votes their 1-bit decisions.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   feature vector handshake (accepts only when idle)
//   in_feat, in_mask    feature vector and per-tree enable, sampled together
//   tree_feat, tree_sel held feature vector and tree index driven to the bank
//   tree_bit            class decision of the currently selected tree
//   out_valid/out_ready result handshake
//   out_class           voted class (TIE_CLASS on a tie or empty mask)
//   out_votes           number of enabled trees that voted 1
//   busy                high while evaluating or holding a result
module tree_vote_sequencer #(
  parameter int   FEAT_W    = 51,
  parameter int   NUM_TREES = 5,
  parameter int   SEL_W     = 3,
  parameter int   VOTE_W    = 4,
  parameter int   TREE_LAT  = 1,
  parameter logic TIE_CLASS = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FEAT_W-1:0]    in_feat,
  input  logic [NUM_TREES-1:0] in_mask,
  output logic [FEAT_W-1:0]    tree_feat,
  output logic [SEL_W-1:0]     tree_sel,
  input  logic                 tree_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_class,
  output logic [VOTE_W-1:0]    out_votes,
  output logic                 busy
);

  localparam logic [2:0] LAT = 3'(TREE_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Lowest enabled index >= start; MSB of the result flags "found".
  function automatic logic [SEL_W:0] f_find(input logic [NUM_TREES-1:0] mask,
                                            input int start);
    logic [SEL_W:0] res;
    res = {1'b0, {SEL_W{1'b0}}};
    for (int i = NUM_TREES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= start)) res = {1'b1, SEL_W'(i)};
    end
    return res;
  endfunction

  // Number of enabled trees.
  function automatic logic [VOTE_W-1:0] f_popcount(input logic [NUM_TREES-1:0] mask);
    logic [VOTE_W-1:0] cnt;
    cnt = {VOTE_W{1'b0}};
    for (int i = 0; i < NUM_TREES; i++) begin
      cnt = cnt + {{(VOTE_W-1){1'b0}}, mask[i]};
    end
    return cnt;
  endfunction

  // Majority decision: compare 2*votes against the number of enabled trees.
  function automatic logic f_class(input logic [VOTE_W-1:0] votes,
                                   input logic [VOTE_W-1:0] enabled);
    logic [VOTE_W:0] dbl;
    logic [VOTE_W:0] en_x;
    logic            cls;
    dbl  = {votes, 1'b0};
    en_x = {1'b0, enabled};
    if (dbl > en_x)       cls = 1'b1;
    else if (dbl == en_x) cls = TIE_CLASS;
    else                  cls = 1'b0;
    return cls;
  endfunction

  state_t                 r_state;
  logic [FEAT_W-1:0]      r_feat;
  logic [NUM_TREES-1:0]   r_mask;
  logic [SEL_W-1:0]       r_sel;
  logic [VOTE_W-1:0]      r_votes;
  logic [2:0]             r_wait;
  logic                   r_valid;
  logic                   r_class;
  logic [VOTE_W-1:0]      r_out_votes;
  logic                   r_busy;

  logic [SEL_W:0]         w_first;
  logic [SEL_W:0]         w_next;
  logic [VOTE_W-1:0]      w_votes_acc;

  assign w_first     = f_find(in_mask, 0);
  assign w_next      = f_find(r_mask, int'(r_sel) + 32'sd1);
  assign w_votes_acc = r_votes + {{(VOTE_W-1){1'b0}}, tree_bit};

  // Sequencer: accept, walk enabled trees with a settle wait, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_feat      <= {FEAT_W{1'b0}};
      r_mask      <= {NUM_TREES{1'b0}};
      r_sel       <= {SEL_W{1'b0}};
      r_votes     <= {VOTE_W{1'b0}};
      r_wait      <= 3'd0;
      r_valid     <= 1'b0;
      r_class     <= 1'b0;
      r_out_votes <= {VOTE_W{1'b0}};
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_feat  <= in_feat;
            r_mask  <= in_mask;
            r_votes <= {VOTE_W{1'b0}};
            r_wait  <= LAT;
            r_busy  <= 1'b1;
            r_state <= S_EVAL;
            // With an empty mask nothing is found and tree_sel stays at 0.
            r_sel   <= w_first[SEL_W] ? w_first[SEL_W-1:0] : {SEL_W{1'b0}};
          end
        end
        S_EVAL: begin
          if (r_mask == {NUM_TREES{1'b0}}) begin
            // Empty mask: one bookkeeping cycle, then publish a zero-vote tie.
            r_state     <= S_DONE;
            r_valid     <= 1'b1;
            r_out_votes <= {VOTE_W{1'b0}};
            r_class     <= TIE_CLASS;
          end else if (r_wait != 3'd0) begin
            r_wait <= r_wait - 3'd1;
          end else begin
            r_votes <= w_votes_acc;
            if (w_next[SEL_W]) begin
              r_sel  <= w_next[SEL_W-1:0];
              r_wait <= LAT;
            end else begin
              r_state     <= S_DONE;
              r_valid     <= 1'b1;
              r_out_votes <= w_votes_acc;
              r_class     <= f_class(w_votes_acc, f_popcount(r_mask));
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign tree_feat = r_feat;
  assign tree_sel  = r_sel;
  assign out_valid = r_valid;
  assign out_class = r_class;
  assign out_votes = r_out_votes;
  assign busy      = r_busy;

endmodule

// File: tb/tb_tree_vote_sequencer.sv
module tb_tree_vote_sequencer;

  localparam int TL = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [50:0] in_feat;
  logic [4:0]  in_mask;
  logic        out_ready;
  logic [4:0]  bits;

  logic        in_ready0, in_ready1;
  logic [50:0] tree_feat0, tree_feat1;
  logic [2:0]  tree_sel0, tree_sel1;
  logic        tree_bit0, tree_bit1;
  logic        out_valid0, out_valid1;
  logic        out_class0, out_class1;
  logic [3:0]  out_votes0, out_votes1;
  logic        busy0, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Tree bank model: tree i decides bits[i].
  assign tree_bit0 = (tree_sel0 < 3'd5) ? bits[tree_sel0] : 1'b0;
  assign tree_bit1 = (tree_sel1 < 3'd5) ? bits[tree_sel1] : 1'b0;

  tree_vote_sequencer #(.TIE_CLASS(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_feat(in_feat), .in_mask(in_mask), .tree_feat(tree_feat0),
    .tree_sel(tree_sel0), .tree_bit(tree_bit0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_class(out_class0), .out_votes(out_votes0),
    .busy(busy0)
  );

  tree_vote_sequencer #(.TIE_CLASS(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_feat(in_feat), .in_mask(in_mask), .tree_feat(tree_feat1),
    .tree_sel(tree_sel1), .tree_bit(tree_bit1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_class(out_class1), .out_votes(out_votes1),
    .busy(busy1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  mask;
    logic [4:0]  bits;
    logic [50:0] feat;
    logic [3:0]  votes;
    logic        cls0;
    logic        cls1;
    int          lat;
  } vec_t;

  vec_t vt[8];

  initial begin
    int          n;
    bit          feat_ok;
    bit          stable_ok;
    bit          stale;
    int          exp_sel[$];
    int          got_sel[$];
    logic [63:0] rnd;

    vt[0] = '{5'b11111, 5'b01101, 51'h1234_5678_9ABC, 4'd3, 1'b1, 1'b1, 10};
    vt[1] = '{5'b00110, 5'b00010, 51'h7_0F0F_0F0F_0F0F, 4'd1, 1'b0, 1'b1, 4};
    vt[2] = '{5'b00000, 5'b11111, 51'h5_5555_5555_5555, 4'd0, 1'b0, 1'b1, 1};
    vt[3] = '{5'b10001, 5'b00000, 51'h2_AAAA_0000_1111, 4'd0, 1'b0, 1'b0, 4};
    vt[4] = '{5'b10101, 5'b10100, 51'h0_0000_0000_0001, 4'd2, 1'b1, 1'b1, 6};
    vt[5] = '{5'b01000, 5'b11111, 51'h4_0000_0000_0000, 4'd1, 1'b1, 1'b1, 2};
    vt[6] = '{5'b11111, 5'b01010, 51'h3_DEAD_BEEF_CAFE, 4'd2, 1'b0, 1'b0, 10};
    vt[7] = '{5'b01011, 5'b10100, 51'h6_1357_9BDF_2468, 4'd0, 1'b0, 1'b0, 6};

    rst = 1'b1; in_valid = 1'b0; in_feat = '0; in_mask = '0;
    out_ready = 1'b0; bits = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_tree_feat", tree_feat0, 51'd0);
    chk("rst_tree_sel", tree_sel0, 3'd0);
    chk("rst_out_votes", out_votes0, 4'd0);
    chk("rst_out_class", out_class0, 1'b0);
    chk("rst_in_ready", in_ready0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      exp_sel.delete();
      got_sel.delete();
      for (int i = 0; i < 5; i++)
        if (vt[k].mask[i]) for (int r = 0; r <= TL; r++) exp_sel.push_back(i);
      if (vt[k].mask == 5'b00000) exp_sel.push_back(0);

      in_valid = 1'b1; in_feat = vt[k].feat; in_mask = vt[k].mask;
      bits = vt[k].bits; out_ready = 1'b0;
      chk($sformatf("v%0d_in_ready", k), in_ready0, 1'b1);
      n = 0; feat_ok = 1'b1;
      while (n < 64) begin
        @(negedge clk);
        if (out_valid0) break;
        got_sel.push_back(int'(tree_sel0));
        if (tree_feat0 !== vt[k].feat || busy0 !== 1'b1) feat_ok = 1'b0;
        n++;
        rnd = {$urandom(), $urandom()};
        in_valid = rnd[0];
        in_feat  = 51'(rnd);
        in_mask  = 5'(rnd >> 7);
      end
      chk($sformatf("v%0d_latency", k), n, vt[k].lat);
      chk($sformatf("v%0d_sel_len", k), got_sel.size(), exp_sel.size());
      for (int i = 0; i < got_sel.size() && i < exp_sel.size(); i++)
        chk($sformatf("v%0d_sel%0d", k, i), got_sel[i], exp_sel[i]);
      chk($sformatf("v%0d_feat_held", k), feat_ok, 1'b1);
      chk($sformatf("v%0d_votes", k), out_votes0, vt[k].votes);
      chk($sformatf("v%0d_class_tie0", k), out_class0, vt[k].cls0);
      chk($sformatf("v%0d_votes_b", k), out_votes1, vt[k].votes);
      chk($sformatf("v%0d_class_tie1", k), out_class1, vt[k].cls1);

      // Backpressure: result must hold and new requests are ignored.
      stable_ok = 1'b1;
      for (int j = 0; j < 5; j++) begin
        in_valid = (j % 2 == 0);
        in_feat  = ~vt[k].feat;
        @(negedge clk);
        if (out_valid0 !== 1'b1 || out_votes0 !== vt[k].votes ||
            out_class0 !== vt[k].cls0 || in_ready0 !== 1'b0 || busy0 !== 1'b1 ||
            tree_feat0 !== vt[k].feat ||
            int'(tree_sel0) != exp_sel[exp_sel.size()-1])
          stable_ok = 1'b0;
      end
      chk($sformatf("v%0d_hold", k), stable_ok, 1'b1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_post_valid", k), out_valid0, 1'b0);
      chk($sformatf("v%0d_post_ready", k), in_ready0, 1'b1);
      chk($sformatf("v%0d_post_busy", k), busy0, 1'b0);
      out_ready = 1'b0;
    end

    // Reset while evaluating tree 2.
    @(negedge clk);
    in_valid = 1'b1; in_feat = 51'h1_FFFF_0000_FFFF; in_mask = 5'b11111;
    bits = 5'b11111;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (tree_sel0 != 3'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_sel2", tree_sel0, 3'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", out_valid0, 1'b0);
    chk("abort_busy", busy0, 1'b0);
    chk("abort_tree_feat", tree_feat0, 51'd0);
    chk("abort_tree_sel", tree_sel0, 3'd0);
    chk("abort_in_ready_in_rst", in_ready0, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", in_ready0, 1'b1);
    stale = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (out_valid0 || busy0) stale = 1'b1;
    end
    chk("abort_no_stale", stale, 1'b0);

    // Back-to-back: A (trees 0,1) then B (tree 2) with valid/ready held high.
    bits = 5'b00101;
    in_valid = 1'b1; in_feat = 51'h0_AAAA_AAAA_AAAA; in_mask = 5'b00011;
    out_ready = 1'b1;
    @(negedge clk);
    in_feat = 51'h0_BBBB_BBBB_BBBB; in_mask = 5'b00100;
    n = 1;
    while (n < 64) begin
      @(negedge clk);
      if (out_valid0) break;
      n++;
    end
    chk("b2b_a_latency", n, 4);
    chk("b2b_a_votes", out_votes0, 4'd1);
    chk("b2b_a_class", out_class0, 1'b0);
    chk("b2b_a_feat", tree_feat0, 51'h0_AAAA_AAAA_AAAA);
    @(negedge clk);
    chk("b2b_gap_valid", out_valid0, 1'b0);
    chk("b2b_gap_ready", in_ready0, 1'b1);
    chk("b2b_gap_feat", tree_feat0, 51'h0_AAAA_AAAA_AAAA);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_b_feat", tree_feat0, 51'h0_BBBB_BBBB_BBBB);
    chk("b2b_b_busy", busy0, 1'b1);
    chk("b2b_b_sel", tree_sel0, 3'd2);
    n = 1;
    while (n < 64) begin
      @(negedge clk);
      if (out_valid0) break;
      n++;
    end
    chk("b2b_b_latency", n, 2);
    chk("b2b_b_votes", out_votes0, 4'd1);
    chk("b2b_b_class", out_class0, 1'b1);
    @(negedge clk);
    chk("b2b_end_ready", in_ready0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
